// File: rtl/ex_stage_handshake_ctrl_if.sv
// EX-stage handshake bundle: ID->EX valids in, EX->MEM valids out,
// plus the control strobes for the shared multi-cycle unit.
interface ex_stage_handshake_ctrl_if;

  logic line1_now_valid_i;
  logic line2_now_valid_i;
  logic line1_long_op_i;
  logic line2_long_op_i;
  logic next_allowin_i;
  logic excep_flush_i;
  logic now_allowin_o;
  logic line1_now_to_next_valid_o;
  logic line2_now_to_next_valid_o;
  logic mc_start_o;
  logic mc_line_o;
  logic mc_busy_o;

  modport master (
    output line1_now_valid_i,
    output line2_now_valid_i,
    output line1_long_op_i,
    output line2_long_op_i,
    output next_allowin_i,
    output excep_flush_i,
    input  now_allowin_o,
    input  line1_now_to_next_valid_o,
    input  line2_now_to_next_valid_o,
    input  mc_start_o,
    input  mc_line_o,
    input  mc_busy_o
  );

  modport slave (
    input  line1_now_valid_i,
    input  line2_now_valid_i,
    input  line1_long_op_i,
    input  line2_long_op_i,
    input  next_allowin_i,
    input  excep_flush_i,
    output now_allowin_o,
    output line1_now_to_next_valid_o,
    output line2_now_to_next_valid_o,
    output mc_start_o,
    output mc_line_o,
    output mc_busy_o
  );

endinterface

// File: rtl/ex_stage_handshake_ctrl.sv
// Dual-issue EX handshake; long ops share one multi-cycle unit.
// Define EX_LONG_OP_EN to build the long-op sequencer, else pass-through.
module ex_stage_handshake_ctrl #(
  parameter int unsigned LONG_LAT = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  ex_stage_handshake_ctrl_if.slave  bus
);

  localparam logic [7:0] RELOAD = 8'(LONG_LAT - 1);

  logic any_valid;
  logic ready_go;

  assign any_valid = bus.line1_now_valid_i
                   | bus.line2_now_valid_i;

`ifdef EX_LONG_OP_EN

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       l1_long;
  logic       l2_long;
  logic       start;
  logic       start_line;
  logic       start_ok;

  assign l1_long = bus.line1_now_valid_i
                 & bus.line1_long_op_i;
  assign l2_long = bus.line2_now_valid_i
                 & bus.line2_long_op_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start      = 1'b0;
    start_line = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (l1_long) begin
          start   = 1'b1;
          state_d = EXEC1;
          cnt_d   = RELOAD;
        end else if (l2_long) begin
          start      = 1'b1;
          start_line = 1'b1;
          state_d    = EXEC2;
          cnt_d      = RELOAD;
        end
      end
      EXEC1: begin
        if (cnt_q == 8'd0) begin
          // line 2 only issues once line 1 has left the unit
          if (l2_long) begin
            start      = 1'b1;
            start_line = 1'b1;
            state_d    = EXEC2;
            cnt_d      = RELOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      EXEC2: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        if (bus.next_allowin_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // flush beats every other transition
    if (bus.excep_flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      start   = 1'b0;
    end
  end

  assign start_ok = start & rst_n;

  assign ready_go = (state_q == DONE)
                  | ((state_q == IDLE)
                     & ~l1_long
                     & ~l2_long);

  assign bus.mc_start_o = start_ok;
  assign bus.mc_line_o  = start_ok ? start_line
                        : (state_q == EXEC2);
  assign bus.mc_busy_o  = (state_q == EXEC1)
                        | (state_q == EXEC2);

`else

  logic unused_ok;

  assign unused_ok = &{1'b0,
                       clk,
                       rst_n,
                       bus.line1_long_op_i,
                       bus.line2_long_op_i,
                       RELOAD};

  assign ready_go       = 1'b1;
  assign bus.mc_start_o = 1'b0;
  assign bus.mc_line_o  = 1'b0;
  assign bus.mc_busy_o  = 1'b0;

`endif

  assign bus.line1_now_to_next_valid_o =
    bus.line1_now_valid_i & ready_go
    & ~bus.excep_flush_i;

  assign bus.line2_now_to_next_valid_o =
    bus.line2_now_valid_i & ready_go
    & ~bus.excep_flush_i;

  assign bus.now_allowin_o = ~any_valid
                           | (ready_go & bus.next_allowin_i)
                           | bus.excep_flush_i;

endmodule

// File: tb/tb_ex_stage_handshake_ctrl.sv
// Bench for ex_stage_handshake_ctrl: directed scenarios plus a random
// run against a bundle-schedule reference model.
module tb_ex_stage_handshake_ctrl;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  ex_stage_handshake_ctrl_if bus ();

  ex_stage_handshake_ctrl #(
    .LONG_LAT(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // {allowin, l1_next, l2_next, start, line, busy}
  function automatic logic [5:0] obs();
    return {bus.now_allowin_o,
            bus.line1_now_to_next_valid_o,
            bus.line2_now_to_next_valid_o,
            bus.mc_start_o,
            bus.mc_line_o,
            bus.mc_busy_o};
  endfunction

  // k = cycles since the bundle arrived in EX
  function automatic logic [5:0] model(
    input logic v1, input logic v2,
    input logic g1, input logic g2,
    input logic na, input logic fl,
    input int k);
    logic l1, l2, rdy, st, bsy, ln;
    int n;
`ifdef EX_LONG_OP_EN
    l1 = v1 & g1;
    l2 = v2 & g2;
`else
    l1 = 1'b0;
    l2 = 1'b0;
`endif
    n   = int'(l1) + int'(l2);
    rdy = (n == 0) || (k >= n * LAT + 1);
    st  = !fl && (n >= 1)
          && (k == 0 || (n == 2 && k == LAT));
    bsy = (n >= 1) && (k >= 1) && (k <= n * LAT);
    if (st) ln = (k == 0) ? !l1 : 1'b1;
    else    ln = bsy && (!l1 || k > LAT);
    return {(!(v1 | v2)) | (rdy & na) | fl,
            v1 & rdy & !fl,
            v2 & rdy & !fl,
            st, ln, bsy};
  endfunction

  task automatic drive(input logic v1, input logic v2,
                       input logic g1, input logic g2,
                       input logic na, input logic fl);
    bus.line1_now_valid_i = v1;
    bus.line2_now_valid_i = v2;
    bus.line1_long_op_i   = g1;
    bus.line2_long_op_i   = g2;
    bus.next_allowin_i    = na;
    bus.excep_flush_i     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] o;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    tick();
    tick();
    @(negedge clk);
    o = obs();
    n_cmp++;
    if (o !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_outs: got %b want %b",
               o, 6'b100000);
    end
    tick();
    drive(1, 1, 1, 1, 1, 0);
    @(negedge clk);
    n_cmp++;
    if (bus.mc_start_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_start: got %b want 0",
               bus.mc_start_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic v1, v2, g1, g2;
    logic [5:0] o, e;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      v1 = 1'($urandom_range(0, 1));
      v2 = 1'($urandom_range(0, 1));
      g1 = !v1 & 1'($urandom_range(0, 1));
      g2 = !v2 & 1'($urandom_range(0, 1));
      drive(v1, v2, g1, g2, 1, 0);
      @(negedge clk);
      o = obs();
      e = {1'b1, v1, v2, 3'b000};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL b2b i%0d: got %b want %b",
                 i, o, e);
      end
      tick();
    end
  endtask

  task automatic test_flush_pass();
    logic v1, v2, na;
    logic [5:0] o;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v1 = 1'($urandom_range(0, 1));
      v2 = 1'($urandom_range(0, 1));
      na = 1'($urandom_range(0, 1));
      drive(v1, v2, 0, 0, na, 1);
      @(negedge clk);
      o = obs();
      n_cmp++;
      if (o !== 6'b100000) begin
        n_err++;
        $display("FAIL flush_gate i%0d: got %b want %b",
                 i, o, 6'b100000);
      end
      tick();
    end
  endtask

`ifdef EX_LONG_OP_EN

  task automatic test_one_long();
    logic [5:0] o, e;
    do_reset();
    drive(1, 1, 1, 0, 1, 0);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      o = obs();
      e = {c >= 5, c == 5, c == 5, c == 0,
           1'b0, c >= 1 && c <= 4};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL one_long c%0d: got %b want %b",
                 c, o, e);
      end
      tick();
      if (c == 5) drive(0, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_two_long();
    logic [5:0] o, e;
    do_reset();
    drive(1, 1, 1, 1, 1, 0);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      o = obs();
      e = {c >= 9, c == 9, c == 9,
           c == 0 || c == 4,
           c >= 4 && c <= 8,
           c >= 1 && c <= 8};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL two_long c%0d: got %b want %b",
                 c, o, e);
      end
      tick();
      if (c == 9) drive(0, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_stall();
    logic [5:0] o, e;
    do_reset();
    drive(1, 1, 1, 0, 1, 0);
    for (int c = 0; c <= 9; c++) begin
      bus.next_allowin_i = !(c >= 5 && c <= 7);
      @(negedge clk);
      o = obs();
      e = {c >= 8, c >= 5 && c <= 8,
           c >= 5 && c <= 8, c == 0,
           1'b0, c >= 1 && c <= 4};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL stall c%0d: got %b want %b",
                 c, o, e);
      end
      tick();
      if (c == 8) drive(0, 0, 0, 0, 1, 0);
    end
  endtask

  task automatic test_flush_exec1();
    logic [5:0] o, e;
    do_reset();
    drive(1, 1, 1, 0, 1, 0);
    for (int c = 0; c <= 3; c++) begin
      bus.excep_flush_i = (c == 2);
      @(negedge clk);
      o = obs();
      e = {c == 2, 1'b0, 1'b0,
           c == 0 || c == 3, 1'b0,
           c == 1 || c == 2};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL flush_exec1 c%0d: got %b want %b",
                 c, o, e);
      end
      tick();
    end
  endtask

  task automatic test_flush_cnt0();
    logic [5:0] o, e;
    do_reset();
    drive(1, 1, 1, 0, 1, 0);
    for (int c = 0; c <= 5; c++) begin
      bus.excep_flush_i = (c == 4);
      @(negedge clk);
      o = obs();
      e = {c == 4, 1'b0, 1'b0,
           c == 0 || c == 5, 1'b0,
           c >= 1 && c <= 4};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL flush_cnt0 c%0d: got %b want %b",
                 c, o, e);
      end
      tick();
    end
  endtask

  task automatic test_reset_exec2();
    logic [5:0] o, e;
    do_reset();
    drive(1, 1, 1, 1, 1, 0);
    for (int c = 0; c <= 7; c++) begin
      if (c == 6) rst_n = 1'b0;
      @(negedge clk);
      o = obs();
      e = {1'b0, 1'b0, 1'b0,
           c == 0 || c == 4,
           c >= 4 && c <= 6,
           c >= 1 && c <= 6};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_exec2 c%0d: got %b want %b",
                 c, o, e);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

`else

  task automatic test_long_ignored();
    logic v1, v2;
    logic [5:0] o, e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      v1 = 1'($urandom_range(0, 1));
      v2 = 1'($urandom_range(0, 1));
      drive(v1, v2, 1, 1, 1, 0);
      @(negedge clk);
      o = obs();
      e = {1'b1, v1, v2, 3'b000};
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL long_ignored i%0d: got %b want %b",
                 i, o, e);
      end
      tick();
    end
  endtask

`endif

  task automatic test_random();
    logic v1, v2, g1, g2, na, fl;
    logic [5:0] o, e;
    int k;
    do_reset();
    k  = 0;
    v1 = 1'($urandom_range(0, 1));
    v2 = 1'($urandom_range(0, 1));
    g1 = 1'($urandom_range(0, 1));
    g2 = 1'($urandom_range(0, 1));
    for (int i = 0; i < 600; i++) begin
      na = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 24) == 0);
      drive(v1, v2, g1, g2, na, fl);
      @(negedge clk);
      o = obs();
      e = model(v1, v2, g1, g2, na, fl, k);
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random i%0d k%0d: got %b want %b",
                 i, k, o, e);
      end
      tick();
      if (e[5]) begin
        k  = 0;
        v1 = 1'($urandom_range(0, 1));
        v2 = 1'($urandom_range(0, 1));
        g1 = 1'($urandom_range(0, 1));
        g2 = 1'($urandom_range(0, 1));
      end else begin
        k++;
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 1, 0);
    test_reset();
    test_back_to_back();
    test_flush_pass();
`ifdef EX_LONG_OP_EN
    test_one_long();
    test_two_long();
    test_stall();
    test_flush_exec1();
    test_flush_cnt0();
    test_reset_exec2();
`else
    test_long_ignored();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage_handshake_ctrl.md
# ex_stage_handshake_ctrl

Stage-side handshake controller for the dual-issue EX stage. It consumes the per-line valids held by the ID→EX pipeline register and returns `now_allowin` to it. It sequences up to two multi-cycle ("long") operations per bundle through one shared multi-cycle unit. It drives per-line valids toward EX→MEM, gated by downstream backpressure and exception flush.

## Interface
- `LONG_LAT`, default 4: cycles a long op occupies the shared unit; legal range 2..255.
- `clk` in, 1: clock.
- `rst_n` in, 1: reset, synchronous, active-low.
- `line1_now_valid_i` in, 1: line-1 instruction valid in EX (from ID→EX register).
- `line2_now_valid_i` in, 1: line-2 instruction valid in EX.
- `line1_long_op_i` in, 1: line-1 op needs the multi-cycle unit.
- `line2_long_op_i` in, 1: line-2 op needs the multi-cycle unit.
- `next_allowin_i` in, 1: EX→MEM register can accept.
- `excep_flush_i` in, 1: exception flush.
- `now_allowin_o` out, 1: to ID→EX register; EX can accept a new bundle.
- `line1_now_to_next_valid_o` out, 1: line-1 result valid toward MEM.
- `line2_now_to_next_valid_o` out, 1: line-2 result valid toward MEM.
- `mc_start_o` out, 1: one-cycle start pulse to the multi-cycle unit.
- `mc_line_o` out, 1: line whose operands drive the unit (0 = line 1, 1 = line 2).
- `mc_busy_o` out, 1: unit occupied (state EXEC1 or EXEC2).

## Operation
- `any_valid` = line1 valid | line2 valid.
- `lN_long` = `lineN_now_valid_i & lineN_long_op_i`. A long flag on an invalid line is ignored.
- FSM states: IDLE, EXEC1, EXEC2, DONE. Down-counter `cnt` is 8 bits.
- IDLE:
  - If `l1_long`: assert `mc_start_o` with `mc_line_o=0`; next state EXEC1, `cnt<=LONG_LAT-1`.
  - Else if `l2_long`: assert `mc_start_o` with `mc_line_o=1`; next state EXEC2, `cnt<=LONG_LAT-1`.
  - Else stay in IDLE.
- EXEC1:
  - `cnt` decrements each cycle.
  - At `cnt==0`: if `l2_long`, assert `mc_start_o` with `mc_line_o=1`, next state EXEC2, reload `cnt`; otherwise next state DONE.
- EXEC2: `cnt` decrements each cycle; at `cnt==0`, next state DONE.
- DONE: when `next_allowin_i`, next state IDLE; otherwise hold.
- `mc_line_o` = 1 in EXEC2, 0 otherwise, except during the IDLE/EXEC1 start pulses defined above.
- `ready_go` = (state==DONE) | (state==IDLE & !l1_long & !l2_long).
- `lineN_now_to_next_valid_o` = `lineN_now_valid_i & ready_go & !excep_flush_i`.
- `now_allowin_o` = `!any_valid | (ready_go & next_allowin_i) | excep_flush_i`.
- Lines leave as a bundle: both lines' to_next valids rise in the same cycle. Line 2 never overtakes line 1.
- Flush: the next edge forces state IDLE and `cnt=0`. `mc_start_o` is suppressed in a flush cycle. The unit's in-flight result is discarded by the unit owner.
- Reset: state IDLE, `cnt=0`. `mc_start_o` is forced 0 while `rst_n==0`. With upstream valids reset to 0, the outputs are: `now_allowin_o=1`, both to_next valids 0, `mc_busy_o=0`, `mc_line_o=0`.

## Timing
- Bundle with no long op: zero added latency. `ready_go` holds in its arrival cycle, and `now_allowin_o` follows `next_allowin_i` combinationally.
- One long op (either line):
  - Arrival is cycle 0; `mc_start_o` pulses in cycle 0.
  - `cnt` runs LONG_LAT-1 down to 0 over cycles 1..LONG_LAT.
  - DONE and `ready_go` in cycle LONG_LAT+1.
- Two long ops: line-2 `mc_start_o` pulses in cycle LONG_LAT; `ready_go` in cycle 2·LONG_LAT+1.
- A stalled DONE (`next_allowin_i=0`) holds the valids and never restarts the unit.
- Back-to-back bundles:
  - The DONE→IDLE transition and the new-bundle load share one edge.
  - The new bundle is examined in IDLE the following cycle, so there is no bubble.
- Flush in any state: outputs are gated in the same cycle, and the state is IDLE on the next cycle.
- Flush coincident with a `cnt==0` transition: flush wins.

## Configuration
- `EX_LONG_OP_EN` defined: behaviour as described above.
- `EX_LONG_OP_EN` undefined:
  - The long-op inputs are ignored; the FSM and counter are not built.
  - `ready_go=1`.
  - `mc_start_o`, `mc_line_o` and `mc_busy_o` are tied to 0.
  - The stage becomes a pure pass-through handshake.

## Test plan
- LONG_LAT=4, line1 valid with long op, line2 valid without, `next_allowin_i=1`:
  - `mc_start_o` in cycle 0 only.
  - Both to_next valids high in cycle 5 only.
  - `now_allowin_o` 0 in cycles 0–4 and 1 in cycle 5.
- Both lines long, LONG_LAT=4:
  - Starts in cycle 0 (`mc_line_o=0`) and cycle 4 (`mc_line_o=1`).
  - `ready_go` in cycle 9.
  - `mc_busy_o` high in cycles 1–8.
- Single long op completes while `next_allowin_i=0` for 3 cycles:
  - Valids held for cycles 5–7.
  - No extra `mc_start_o`.
  - Handoff in cycle 8 when `next_allowin_i` returns to 1.
- `excep_flush_i` pulsed in cycle 2 of EXEC1:
  - Valids 0 and `now_allowin_o=1` in cycle 2.
  - State IDLE and `cnt=0` in cycle 3.
- Non-long bundles every cycle with `next_allowin_i=1`:
  - `now_allowin_o` stays 1.
  - to_next valids track the inputs with 0 cycles delay.
- Synchronous reset asserted mid-EXEC2:
  - The next cycle shows IDLE and `mc_busy_o=0`.
  - No `mc_start_o` while `rst_n=0`.
